ss_seq: RTL and testbench

Save-state sequencer: the initiator for the mapper save-state port. On a save command it walks mapper save-state addresses, samples `ss_rdat` and writes each byte to snapshot memory. On a load command it reads snapshot memory and drives the bytes back through `ss_we`. It sits between the system controller and the active mapper's `ss_ctrl` inputs, with a single clock and a request/acknowledge memory port.

---
 rtl/ss_seq.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ss_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_seq.sv
// ss_seq: save-state sequencer driving a mapper's save-state port.
// On a save it reads mapper slots 0..LAST_REG plus index slot 127 and writes
// them to snapshot memory. On a load it reads snapshot memory and strobes the
// bytes back into the mapper.
// Optional feature macro: SS_IDXCHK_EN. When defined, a load first compares
// the stored index byte (slot 127) with the mapper's live index. A mismatch
// aborts with an err pulse before any ss_we strobe.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, op_load        command pulse and direction (0 save, 1 load)
//   busy, done, err       status; done/err are one-cycle pulses
//   ss_act, ss_we         save-state mode enable and register write strobe
//   ss_addr, ss_wdat      mapper slot and restore data
//   ss_rdat               mapper readback data
//   mem_req, mem_we       snapshot memory request (held until mem_ack), write
//   mem_addr, mem_wdat    snapshot slot and write data
//   mem_rdat, mem_ack     read data (valid with ack) and one-cycle ack
module ss_seq #(
  parameter int unsigned LAST_REG  = 2,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned WE_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdat,
  input  logic [7:0] mem_rdat,
  input  logic       mem_ack
);

  localparam int unsigned CNT_W = 8;
  localparam logic [7:0] IDX_SLOT  = 8'd127;
  localparam logic [7:0] LAST_SLOT = 8'(LAST_REG);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LAST    = CNT_W'(WE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SETUP  = 4'd1,
    S_SAMPLE = 4'd2,
    S_MEM_W  = 4'd3,
    S_MEM_R  = 4'd4,
    S_STROBE = 4'd5,
    S_FIN    = 4'd6
`ifdef SS_IDXCHK_EN
    ,
    S_CHK_RD  = 4'd7,
    S_CHK_CMP = 4'd8
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ss_act_q, ss_act_d;
  logic             ss_we_q, ss_we_d;
  logic [7:0]       ss_addr_q, ss_addr_d;
  logic [7:0]       ss_wdat_q, ss_wdat_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdat_q, mem_wdat_d;
  logic [7:0]       nxt_slot;
`ifdef SS_IDXCHK_EN
  logic             err_q, err_d;
  logic [7:0]       idx_q, idx_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ss_act_q   <= 1'b0;
      ss_we_q    <= 1'b0;
      ss_addr_q  <= '0;
      ss_wdat_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wdat_q <= '0;
`ifdef SS_IDXCHK_EN
      err_q      <= 1'b0;
      idx_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ss_act_q   <= ss_act_d;
      ss_we_q    <= ss_we_d;
      ss_addr_q  <= ss_addr_d;
      ss_wdat_q  <= ss_wdat_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdat_q <= mem_wdat_d;
`ifdef SS_IDXCHK_EN
      err_q      <= err_d;
      idx_q      <= idx_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ss_act_d   = ss_act_q;
    ss_we_d    = ss_we_q;
    ss_addr_d  = ss_addr_q;
    ss_wdat_d  = ss_wdat_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdat_d = mem_wdat_q;
    nxt_slot   = slot_q + 8'd1;
`ifdef SS_IDXCHK_EN
    err_d      = 1'b0;
    idx_d      = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          slot_d   = '0;
          cnt_d    = '0;
          op_d     = op_load;
          busy_d   = 1'b1;
          ss_act_d = 1'b1;
          if (!op_load) begin
            state_d   = S_SETUP;
            ss_addr_d = '0;
            ss_wdat_d = '0;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
`ifdef SS_IDXCHK_EN
            state_d    = S_CHK_RD;
            mem_addr_d = IDX_SLOT;
`else
            state_d    = S_MEM_R;
            mem_addr_d = '0;
`endif
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d = '0;
          if (op_q) begin
            state_d = S_STROBE;
            ss_we_d = 1'b1;
          end else begin
            state_d = S_SAMPLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        mem_wdat_d = ss_rdat;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = slot_q;
        state_d    = S_MEM_W;
      end
      S_MEM_W: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (slot_q == IDX_SLOT) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            ss_act_d = 1'b0;
          end else begin
            // After the last register slot the index slot is saved.
            slot_d    = (slot_q == LAST_SLOT) ? IDX_SLOT : nxt_slot;
            ss_addr_d = (slot_q == LAST_SLOT) ? IDX_SLOT : nxt_slot;
            cnt_d     = '0;
            state_d   = S_SETUP;
          end
        end
      end
      S_MEM_R: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ss_wdat_d = mem_rdat;
          ss_addr_d = slot_q;
          cnt_d     = '0;
          state_d   = S_SETUP;
        end
      end
      S_STROBE: begin
        if (cnt_q == WE_LAST) begin
          ss_we_d = 1'b0;
          cnt_d   = '0;
          if (slot_q == LAST_SLOT) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            ss_act_d = 1'b0;
          end else begin
            slot_d     = nxt_slot;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = nxt_slot;
            state_d    = S_MEM_R;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
`ifdef SS_IDXCHK_EN
      S_CHK_RD: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          idx_d     = mem_rdat;
          ss_addr_d = IDX_SLOT;
          cnt_d     = '0;
          state_d   = S_CHK_CMP;
        end
      end
      S_CHK_CMP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d = '0;
          if (ss_rdat == idx_q) begin
            slot_d     = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
            state_d    = S_MEM_R;
          end else begin
            // Snapshot belongs to a different mapper: abort untouched.
            err_d    = 1'b1;
            busy_d   = 1'b0;
            ss_act_d = 1'b0;
            state_d  = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ss_act   = ss_act_q;
  assign ss_we    = ss_we_q;
  assign ss_addr  = ss_addr_q;
  assign ss_wdat  = ss_wdat_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdat = mem_wdat_q;
`ifdef SS_IDXCHK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ss_seq.sv
// Self-checking bench for ss_seq: table of save/load cases with a memory
// model and mapper model, scoreboard queues for memory transactions and
// ss_we strobes, plus hand-written reset-abort sequence.
module tb_ss_seq;

  localparam int unsigned LAST_REG  = 2;
  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned WE_CYC    = 2;
`ifdef SS_IDXCHK_EN
  localparam bit IDXCHK = 1'b1;
`else
  localparam bit IDXCHK = 1'b0;
`endif

  logic       clk, rst_n, start, op_load;
  logic       busy, done, err, ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdat, mem_rdat;

  logic [7:0] mregs [256];
  logic [7:0] mem   [256];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } mtxn_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } stb_t;

  typedef struct {
    logic             op;
    int               lat;
    logic [2:0][7:0]  d;
    logic [7:0]       idx_mem;
    logic [7:0]       idx_map;
    logic             exp_err;
    int               exp_cyc;
    logic             extra;
  } vec_t;

  mtxn_t mq[$];
  stb_t  sq[$];

  int   n_vec = 0;
  int   n_bad = 0;
  int   lat   = 0;
  bit   mdl_en = 1'b1;
  logic man_ack = 1'b0;

  ss_seq #(
    .LAST_REG (LAST_REG),
    .SETUP_CYC(SETUP_CYC),
    .WE_CYC   (WE_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_load (op_load),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .ss_act  (ss_act),
    .ss_we   (ss_we),
    .ss_addr (ss_addr),
    .ss_wdat (ss_wdat),
    .ss_rdat (ss_rdat),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat),
    .mem_ack (mem_ack)
  );

  assign ss_rdat = mregs[ss_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Snapshot memory model with programmable ack latency
  initial begin : mem_model
    int    wcnt;
    logic  c_we;
    logic [7:0] c_addr, c_wdat;
    mtxn_t e;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdat = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!mdl_en) begin
        mem_ack = man_ack;
        wcnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req) begin
        if (wcnt == 0) begin
          c_we = mem_we; c_addr = mem_addr; c_wdat = mem_wdat;
        end else begin
          chk("mem_hold", {15'd0, mem_we, mem_addr, mem_wdat}, {15'd0, c_we, c_addr, c_wdat});
        end
        if (wcnt == lat) begin
          mem_ack = 1'b1;
          if (mq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL mem_unexpected: got we=%0d addr=%0h, expected none", mem_we, mem_addr);
          end else begin
            e = mq.pop_front();
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdat", mem_wdat, e.data);
          end
          if (mem_we) mem[mem_addr] = mem_wdat;
          else        mem_rdat = mem[mem_addr];
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ss_we strobe monitor: checks width, hold of addr/data, and order
  initial begin : stb_mon
    logic       we_prev;
    int         wlen;
    logic [7:0] c_addr, c_wdat;
    stb_t       e;
    we_prev = 1'b0;
    wlen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ss_we) begin
        if (!we_prev) begin
          c_addr = ss_addr; c_wdat = ss_wdat; wlen = 0;
        end else begin
          chk("we_hold", {16'd0, ss_addr, ss_wdat}, {16'd0, c_addr, c_wdat});
        end
        wlen++;
      end else if (we_prev) begin
        if (sq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL stb_unexpected: got addr=%0h data=%0h, expected none", c_addr, c_wdat);
        end else begin
          e = sq.pop_front();
          chk("stb_addr", c_addr, e.addr);
          chk("stb_data", c_wdat, e.data);
          chk("stb_width", wlen, WE_CYC);
        end
      end
      we_prev = ss_we;
    end
  end

  function automatic vec_t mk(input logic op, input int l, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] im, input logic [7:0] ix,
                              input logic ee, input int cyc, input logic ex);
    vec_t v;
    v.op = op; v.lat = l;
    v.d[0] = a; v.d[1] = b; v.d[2] = c;
    v.idx_mem = im; v.idx_map = ix;
    v.exp_err = ee; v.exp_cyc = cyc; v.extra = ex;
    return v;
  endfunction

  task automatic run_case(input vec_t v, input string nm);
    int   cyc;
    logic got;
    lat = v.lat;
    mregs[127] = v.idx_map;
    mem[127]   = v.idx_mem;
    if (!v.op) begin
      for (int i = 0; i <= int'(LAST_REG); i++) begin
        mregs[i] = v.d[i];
        mem[i]   = 8'h00;
        mq.push_back('{1'b1, 8'(i), v.d[i]});
      end
      mem[127] = 8'h00;
      mq.push_back('{1'b1, 8'd127, v.idx_map});
    end else begin
      for (int i = 0; i <= int'(LAST_REG); i++) mem[i] = v.d[i];
      if (IDXCHK) mq.push_back('{1'b0, 8'd127, 8'h00});
      if (!v.exp_err) begin
        for (int i = 0; i <= int'(LAST_REG); i++) begin
          mq.push_back('{1'b0, 8'(i), 8'h00});
          sq.push_back('{8'(i), v.d[i]});
        end
      end
    end
    @(negedge clk);
    op_load = v.op;
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = v.extra && (cyc == 3 || cyc == 9);
      if (v.extra && cyc == 3) op_load = 1'b1;
      if (done || err) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_done"}, done, !v.exp_err);
      chk({nm, "_err"}, err, v.exp_err);
      chk({nm, "_busy_at_end"}, busy, 0);
      if (v.exp_cyc != 0) chk({nm, "_latency"}, cyc, v.exp_cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_idle"}, {busy, ss_act, ss_we, mem_req}, 0);
    chk({nm, "_mem_left"}, mq.size(), 0);
    chk({nm, "_stb_left"}, sq.size(), 0);
    mq.delete();
    sq.delete();
    if (!v.op) begin
      for (int i = 0; i <= int'(LAST_REG); i++) chk({nm, "_memdata"}, mem[i], v.d[i]);
      chk({nm, "_memidx"}, mem[127], v.idx_map);
    end
  endtask

  initial begin : main
    vec_t vecs[6];
    vecs[0] = mk(1'b0, 0, 8'hC5, 8'h3A, 8'h05, 8'h00, 8'hA8, 1'b0, 17, 1'b0);
    vecs[1] = mk(1'b1, 0, 8'h41, 8'hFF, 8'h07, 8'hA8, 8'hA8, 1'b0, 0, 1'b0);
    vecs[2] = mk(1'b0, 5, 8'hC5, 8'h3A, 8'h05, 8'h00, 8'hA8, 1'b0, 37, 1'b0);
    vecs[3] = mk(1'b1, 5, 8'h12, 8'h34, 8'h56, 8'h5A, 8'h5A, 1'b0, 0, 1'b0);
    vecs[4] = mk(1'b1, 0, 8'h99, 8'h88, 8'h77, 8'h10, 8'h11, IDXCHK, 0, 1'b0);
    vecs[5] = mk(1'b0, 0, 8'h5A, 8'h6B, 8'h7C, 8'h00, 8'h3D, 1'b0, 17, 1'b1);

    for (int i = 0; i < 256; i++) begin
      mregs[i] = 8'h00;
      mem[i]   = 8'h00;
    end
    rst_n = 1'b0;
    start = 1'b0;
    op_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, done, err, ss_act, ss_we, mem_req, mem_we}, 0);
    chk("rst_data", {ss_addr, ss_wdat, mem_addr, mem_wdat}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_case(vecs[i], $sformatf("vec%0d", i));

    // Reset while slot 1 write request is outstanding
    begin
      int   cyc;
      logic hit;
      lat = 3;
      mregs[0] = 8'hE1; mregs[1] = 8'hE2;
      mq.push_back('{1'b1, 8'd0, 8'hE1});
      @(negedge clk);
      op_load = 1'b0;
      start = 1'b1;
      cyc = 0;
      hit = 1'b0;
      while (!hit && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (mem_req && mem_we && mem_addr == 8'd1) hit = 1'b1;
      end
      chk("rstmid_reached", hit, 1);
      mdl_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstmid_ctrl", {busy, done, err, ss_act, ss_we, mem_req, mem_we}, 0);
      chk("rstmid_data", {ss_addr, ss_wdat, mem_addr, mem_wdat}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        chk("late_ack_ignored", {busy, ss_act, mem_req, done}, 0);
      end
      chk("rstmid_mem_left", mq.size(), 0);
      mq.delete();
      mdl_en = 1'b1;
      run_case(mk(1'b0, 0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h44, 1'b0, 17, 1'b0), "post_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
